// File: rtl/sopc_mem_arbiter.sv
// Single-port RAM arbiter for the SOPC: VGA reader, CPU fetch and CPU data
// share one synchronous 32-bit RAM, one grant per cycle, data routed back after RD_LAT.
module sopc_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              v_req,
  input  logic [ADDR_W-1:0] v_addr,
  output logic              v_gnt,
  output logic              v_rvalid,
  output logic [7:0]        v_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_stall
);

  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);
  localparam logic [1:0] PORT_I = 2'd0;
  localparam logic [1:0] PORT_D = 2'd1;
  localparam logic [1:0] PORT_V = 2'd2;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == LIM) ? c : c + 1'b1;
  endfunction

  function automatic logic [7:0] lane_sel(input logic [31:0] w, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  logic          rr;
  logic [CW-1:0] wi, wd;
  logic          i_starved, d_starved;

  assign i_starved = i_req && (wi == LIM);
  assign d_starved = d_req && (wd == LIM);

  // Grant decision: starved CPU port, then VGA, then round-robin CPU
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    v_gnt = 1'b0;
    if (!rst) begin
      if (i_starved && d_starved) begin
        if (rr) i_gnt = 1'b1;
        else    d_gnt = 1'b1;
      end else if (i_starved) begin
        i_gnt = 1'b1;
      end else if (d_starved) begin
        d_gnt = 1'b1;
      end else if (v_req) begin
        v_gnt = 1'b1;
      end else if (i_req && d_req) begin
        if (rr) i_gnt = 1'b1;
        else    d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = !rst && ((i_req && !i_gnt) || (d_req && !d_gnt));
  assign mem_en    = i_gnt || d_gnt || v_gnt;
  assign mem_we    = (d_gnt && d_we) ? d_be : 4'b0000;
  assign mem_wdata = d_wdata;

  always_comb begin
    mem_addr = '0;
    if (v_gnt)      mem_addr = v_addr[ADDR_W-1:2];
    else if (d_gnt) mem_addr = d_addr[ADDR_W-1:2];
    else if (i_gnt) mem_addr = i_addr[ADDR_W-1:2];
  end

  // Word-aligned CPU ports: the byte offset of their addresses has no role
  logic unused_ok;
  assign unused_ok = ^{i_addr[1:0], d_addr[1:0]};

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
      wi <= '0;
      wd <= '0;
    end else begin
      if (i_gnt)      rr <= 1'b0;
      else if (d_gnt) rr <= 1'b1;
      wi <= (i_req && !i_gnt) ? sat_inc(wi) : '0;
      wd <= (d_req && !d_gnt) ? sat_inc(wd) : '0;
    end
  end

  // Read-tracking pipe p0 .. p(RD_LAT-1): valid is control, port/offset are data
  logic       rd_vld_p  [RD_LAT];
  logic [1:0] rd_port_p [RD_LAT];
  logic [1:0] rd_off_p  [RD_LAT];
  logic       rd_load;

  assign rd_load = i_gnt || (d_gnt && !d_we) || v_gnt;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RD_LAT; k++) rd_vld_p[k] <= 1'b0;
    end else begin
      rd_vld_p[0] <= rd_load;
      for (int k = 1; k < RD_LAT; k++) rd_vld_p[k] <= rd_vld_p[k-1];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    rd_port_p[0] <= v_gnt ? PORT_V : (d_gnt ? PORT_D : PORT_I);
    rd_off_p[0]  <= v_addr[1:0];
    for (int k = 1; k < RD_LAT; k++) begin
      rd_port_p[k] <= rd_port_p[k-1];
      rd_off_p[k]  <= rd_off_p[k-1];
    end
  end

  // Pipe tail: steer RAM data to its requester, hold it otherwise
  logic        tail_vld;
  logic [1:0]  tail_port;
  logic [7:0]  v_byte;
  logic [31:0] i_hold, d_hold;
  logic [7:0]  v_hold;

  assign tail_vld  = rd_vld_p[RD_LAT-1];
  assign tail_port = rd_port_p[RD_LAT-1];
  assign v_byte    = lane_sel(mem_rdata, rd_off_p[RD_LAT-1]);
  assign i_rvalid  = tail_vld && (tail_port == PORT_I);
  assign d_rvalid  = tail_vld && (tail_port == PORT_D);
  assign v_rvalid  = tail_vld && (tail_port == PORT_V);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      i_hold <= '0;
      d_hold <= '0;
      v_hold <= '0;
    end else begin
      if (i_rvalid) i_hold <= mem_rdata;
      if (d_rvalid) d_hold <= mem_rdata;
      if (v_rvalid) v_hold <= v_byte;
    end
  end

  assign i_rdata = i_rvalid ? mem_rdata : i_hold;
  assign d_rdata = d_rvalid ? mem_rdata : d_hold;
  assign v_rdata = v_rvalid ? v_byte : v_hold;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Scoreboard bench for sopc_mem_arbiter: instance a (RD_LAT=1) and instance b (RD_LAT=3),
// each with its own behavioural RAM.
module tb_sopc_mem_arbiter;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];

  // ---------------- instance a ----------------
  logic        rst = 1'b1;
  logic        i_req = 0, d_req = 0, d_we = 0, v_req = 0;
  logic [17:0] i_addr = '0, d_addr = '0, v_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;
  logic        i_gnt, d_gnt, v_gnt, i_rvalid, d_rvalid, v_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic [7:0]  v_rdata;
  logic        mem_en, cpu_stall;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  sopc_mem_arbiter #(.ADDR_W(18), .RD_LAT(1), .STARVE_LIM(8)) dut_a (
    .CLOCK_50(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  logic [31:0] ram_a [256];
  logic [31:0] rp_a;
  assign mem_rdata = rp_a;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) ram_a[k] <= 32'h0;
      ram_a[8'h00] <= 32'hFFFF_FFFF;
      ram_a[8'h40] <= 32'hCAFE_0100;
      ram_a[8'h41] <= 32'h1111_0104;
      ram_a[8'h42] <= 32'h2222_0108;
      ram_a[8'h43] <= 32'h3333_010C;
      ram_a[8'h80] <= 32'hAABB_CCDD;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram_a[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rp_a <= ram_a[mem_addr[7:0]];
  end

  // ---------------- instance b (RD_LAT=3) ----------------
  logic        b_rst = 1'b1;
  logic        b_d_req = 0;
  logic [17:0] b_d_addr = '0;
  logic        b_i_gnt, b_d_gnt, b_v_gnt, b_i_rvalid, b_d_rvalid, b_v_rvalid;
  logic [31:0] b_i_rdata, b_d_rdata;
  logic [7:0]  b_v_rdata;
  logic        b_mem_en, b_cpu_stall;
  logic [3:0]  b_mem_we;
  logic [15:0] b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  sopc_mem_arbiter #(.ADDR_W(18), .RD_LAT(3), .STARVE_LIM(8)) dut_b (
    .CLOCK_50(clk), .rst(b_rst),
    .i_req(1'b0), .i_addr(18'h0), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(1'b0), .d_be(4'h0), .d_addr(b_d_addr), .d_wdata(32'h0),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .v_req(1'b0), .v_addr(18'h0), .v_gnt(b_v_gnt), .v_rvalid(b_v_rvalid), .v_rdata(b_v_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall)
  );

  logic [31:0] ram_b [256];
  logic [31:0] rp_b [3];
  assign b_mem_rdata = rp_b[2];

  always @(posedge clk) begin
    if (b_rst) begin
      for (int k = 0; k < 256; k++) ram_b[k] <= 32'h0;
      ram_b[8'h40] <= 32'hCAFE_0100;
      ram_b[8'h41] <= 32'h1111_0104;
      ram_b[8'h42] <= 32'h2222_0108;
    end else if (b_mem_en) begin
      for (int b = 0; b < 4; b++)
        if (b_mem_we[b]) ram_b[b_mem_addr[7:0]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
    end
    rp_b[0] <= ram_b[b_mem_addr[7:0]];
    rp_b[1] <= rp_b[0];
    rp_b[2] <= rp_b[1];
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor a: each rvalid pops the oldest expected read and checks port, data, cycle
  exp_t        ea;
  int          pa;
  logic [31:0] da;
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid || v_rvalid) begin
      pa = v_rvalid ? 2 : (d_rvalid ? 1 : 0);
      da = v_rvalid ? {24'h0, v_rdata} : (d_rvalid ? d_rdata : i_rdata);
      tests++;
      if ($countones({i_rvalid, d_rvalid, v_rvalid}) > 1) begin
        fails++;
        $display("FAIL a_rvalid_onehot: got %b at cycle %0d", {v_rvalid, d_rvalid, i_rvalid}, cyc);
      end else if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_rvalid_unexpected: port %0d data %h at cycle %0d, none expected", pa, da, cyc);
      end else begin
        ea = qa.pop_front();
        if (ea.port != pa || ea.data !== da || ea.cyc != cyc) begin
          fails++;
          $display("FAIL a_rvalid: got port %0d data %h cycle %0d, expected port %0d data %h cycle %0d",
                   pa, da, cyc, ea.port, ea.data, ea.cyc);
        end
      end
    end
  end

  exp_t        eb;
  int          pb;
  always @(negedge clk) begin
    if (b_i_rvalid || b_d_rvalid || b_v_rvalid) begin
      pb = b_v_rvalid ? 2 : (b_d_rvalid ? 1 : 0);
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_rvalid_unexpected: port %0d data %h at cycle %0d, none expected",
                 pb, b_d_rdata, cyc);
      end else begin
        eb = qb.pop_front();
        if (eb.port != pb || eb.data !== b_d_rdata || eb.cyc != cyc) begin
          fails++;
          $display("FAIL b_rvalid: got port %0d data %h cycle %0d, expected port %0d data %h cycle %0d",
                   pb, b_d_rdata, cyc, eb.port, eb.data, eb.cyc);
        end
      end
    end
  end

  // Check grant vector {v,d,i} of instance a and queue the expected read response
  task automatic gnt_a(input string nm, input logic [2:0] eg, input int port, input logic [31:0] data);
    @(negedge clk);
    chk(nm, {29'h0, v_gnt, d_gnt, i_gnt}, {29'h0, eg});
    if (port >= 0) qa.push_back('{port, data, cyc + 1});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all ports requesting: nothing may leak out
    i_req = 1; d_req = 1; v_req = 1; d_addr = 18'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {29'h0, v_gnt, d_gnt, i_gnt}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_we", {28'h0, mem_we}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_v_rdata", {24'h0, v_rdata}, 32'h0);
    @(posedge clk); #1;
    rst = 0; i_req = 0; v_req = 0;

    // Single data read of 0x100
    gnt_a("t1_d_gnt", 3'b010, 1, 32'hCAFE_0100);
    chk("t1_mem_addr", {16'h0, mem_addr}, 32'h40);
    chk("t1_mem_we", {28'h0, mem_we}, 32'h0);
    nxt(); d_req = 0;
    gnt_a("t1_idle", 3'b000, -1, 0);
    nxt();

    // Lone fetch read, granted whatever rr says; leaves data favoured
    i_req = 1; i_addr = 18'h104;
    gnt_a("t1b_i_gnt", 3'b001, 0, 32'h1111_0104);
    nxt(); i_req = 0;
    gnt_a("t1b_idle", 3'b000, -1, 0);
    nxt();

    // Both CPU ports held: d,i,d,i,d,i
    i_req = 1; i_addr = 18'h108; d_req = 1; d_addr = 18'h10C;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) gnt_a("t2_rr_d", 3'b010, 1, 32'h3333_010C);
      else            gnt_a("t2_rr_i", 3'b001, 0, 32'h2222_0108);
      chk("t2_stall", {31'h0, cpu_stall}, 32'h1);
      nxt();
    end
    i_req = 0; d_req = 0;
    gnt_a("t2_idle", 3'b000, -1, 0);
    nxt();

    // Sustained VGA with a data read waiting: pre-empts on its 9th waiting cycle
    v_req = 1; v_addr = 18'h200; d_req = 1; d_addr = 18'h100;
    for (int k = 0; k < 20; k++) begin
      if (k == 8) gnt_a("t3_starve_d", 3'b010, 1, 32'hCAFE_0100);
      else        gnt_a("t3_vga", 3'b100, 2, 32'hDD);
      if (k < 8) chk("t3_stall", {31'h0, cpu_stall}, 32'h1);
      nxt();
      if (k == 8) d_req = 0;
    end

    // VGA byte lanes
    v_addr = 18'h203;
    gnt_a("t4_v3", 3'b100, 2, 32'hAA);
    nxt(); v_addr = 18'h202;
    gnt_a("t4_v2", 3'b100, 2, 32'hBB);
    nxt(); v_req = 0;
    gnt_a("t4_idle", 3'b000, -1, 0);
    nxt();

    // Partial write to word 0 then read back
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 18'h0; d_wdata = 32'h1234_5678;
    gnt_a("t5_wr_gnt", 3'b010, -1, 0);
    chk("t5_mem_we", {28'h0, mem_we}, 32'h3);
    chk("t5_mem_wdata", mem_wdata, 32'h1234_5678);
    nxt(); d_we = 0; d_be = 4'b0000;
    gnt_a("t5_rd_gnt", 3'b010, 1, 32'hFFFF_5678);
    chk("t5_rd_we", {28'h0, mem_we}, 32'h0);
    nxt(); d_req = 0;
    repeat (3) nxt();

    // Instance b: two reads in flight when reset hits, third waits through reset
    b_rst = 0; b_d_req = 1; b_d_addr = 18'h100;
    @(negedge clk); chk("t6_gnt0", {31'h0, b_d_gnt}, 32'h1);
    nxt(); b_d_addr = 18'h104;
    @(negedge clk); chk("t6_gnt1", {31'h0, b_d_gnt}, 32'h1);
    nxt(); b_rst = 1; b_d_addr = 18'h108;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_rst_gnt", {29'h0, b_v_gnt, b_d_gnt, b_i_gnt}, 32'h0);
      chk("t6_rst_en", {31'h0, b_mem_en}, 32'h0);
      chk("t6_rst_stall", {31'h0, b_cpu_stall}, 32'h0);
      chk("t6_rst_rdata", b_d_rdata, 32'h0);
      nxt();
    end
    b_rst = 0;
    @(negedge clk);
    chk("t6_resume_gnt", {31'h0, b_d_gnt}, 32'h1);
    chk("t6_resume_addr", {16'h0, b_mem_addr}, 32'h42);
    qb.push_back('{1, 32'h2222_0108, cyc + 3});
    nxt(); b_d_req = 0;
    repeat (6) nxt();

    chk("qa_drained", qa.size(), 32'h0);
    chk("qb_drained", qb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sopc_mem_arbiter.md
# sopc_mem_arbiter

Single-port memory arbiter for the SOPC: shares one synchronous 32-bit RAM between the CPU instruction-fetch port, the CPU data port and the VGA framebuffer reader. It sits between the CPU core/VGA controller and the on-chip RAM. Arbitration is one grant per cycle: fixed top priority for VGA, round-robin between the two CPU ports, and a starvation guard that lets a waiting CPU port pre-empt VGA. Read data is routed back to the requester after the RAM latency.

## Interface
- ADDR_W, 18, byte address width of all requester ports
- RD_LAT, 1, RAM read latency in cycles (1..3)
- STARVE_LIM, 8, consecutive cycles a CPU port may wait before pre-empting VGA

- CLOCK_50  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch byte address (word aligned; bits [1:0] ignored)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  4  write byte enables
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid
- d_rdata  out  32  read data
- v_req  in  1  VGA pixel read request
- v_addr  in  ADDR_W  VGA byte address
- v_gnt  out  1  VGA request accepted
- v_rvalid  out  1  pixel valid
- v_rdata  out  8  pixel byte, lane selected by v_addr[1:0]
- mem_en  out  1  RAM access enable
- mem_we  out  4  RAM byte write enables
- mem_addr  out  ADDR_W-2  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid RD_LAT cycles after mem_en
- cpu_stall  out  1  (i_req & ~i_gnt) | (d_req & ~d_gnt)

## Operation
- Grants are combinational from the current requests and registered state; at most one of i_gnt/d_gnt/v_gnt is high per cycle; the granted port's address/data drive mem_* in the same cycle.
- Priority: if a starved CPU port exists, grant it; else VGA if v_req; else the CPU port selected by round-robin.
- Round-robin pointer rr (0 = data favoured, 1 = fetch favoured): when both CPU ports request, grant the favoured one; after any CPU grant rr points to the other CPU port. A lone CPU request is granted regardless of rr.
- Starvation counters wi, wd (saturating, width ceil(log2(STARVE_LIM+1))): increment each cycle the port requests and is not granted; clear on grant or when req is low. Port is starved when its counter == STARVE_LIM. If both are starved, rr decides.
- mem_we = d_be when d_gnt & d_we, else 4'b0000. mem_en = any grant.
- Read tracking: RD_LAT-deep shift register of {valid, port[1:0], byte_off[1:0]} loaded on every read grant (writes load valid=0). At the tail, the matching *_rvalid pulses for one cycle with mem_rdata (VGA: byte lane byte_off, lane 0 = bits [7:0]).
- *_rdata hold their last value when rvalid is low.
- No request cancellation: a requester keeps req/addr stable until gnt.

## Timing
- Reset (async assert): rr = 0, wi = wd = 0, read pipe cleared; all gnt, rvalid, mem_en, mem_we, cpu_stall = 0 while rst is high; rdata = 0. In-flight reads at reset are dropped, no rvalid.
- Grant-to-rvalid latency = RD_LAT cycles exactly; back-to-back reads give one rvalid per cycle in grant order.
- Write: data in RAM at the grant edge; a read of the same word granted the next cycle returns new data.
- Sustained v_req with a CPU port requesting: the CPU port is granted on its (STARVE_LIM+1)-th waiting cycle, then VGA resumes.
- Simultaneous i_req and d_req with no VGA: grants alternate every cycle.

## Test plan
- Reset release, RD_LAT=1: d_req read of 0x100 at cycle 0 -> d_gnt cycle 0, mem_addr=0x40, d_rvalid cycle 1 with RAM word; no other gnt/rvalid.
- i_req and d_req held 6 cycles, rr=0 -> grants d,i,d,i,d,i; cpu_stall=1 every cycle; rvalids follow one cycle later in the same order.
- v_req held 20 cycles plus d_req from cycle 0, STARVE_LIM=8 -> v_gnt cycles 0-7, d_gnt cycle 8, v_gnt resumes cycle 9.
- VGA reads at 0x203, 0x202 with word 0xAABBCCDD -> v_rdata 0xAA then 0xBB on consecutive cycles.
- d write 0x12345678, d_be=4'b0011 to word 0 over 0xFFFFFFFF, then read -> d_rdata 0xFFFF5678; write produces no d_rvalid.
- RD_LAT=3, three reads granted, rst pulsed after the second grant -> zero rvalids during and after reset, outputs all 0, normal grants resume cycle after release.
